fifo_rd_drain: RTL

FIFO_RD_DRAIN -- requirements
Module: fifo_rd_drain

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_rd_drain_if.sv | 36 +++
 rtl/fifo_rd_drain.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared definitions for the FIFO read-side blocks.
//   DATA_WIDTH  : default width of FIFO words and downstream stream data.
//   occ_state_e : occupancy of the 2-entry skid buffer in fifo_rd_drain.
package fifo_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/fifo_rd_drain_if.sv
// fifo_rd_drain_if -- FIFO read port plus downstream valid/ready stream.
//   empty, data_out : FIFO status and first-word-fall-through head word.
//   rd_en           : FIFO pop strobe.
//   m_data, m_valid : downstream stream data and valid.
//   m_ready         : downstream ready.
// Modport master is the drain block; modport slave is the FIFO/sink side.
interface fifo_rd_drain_if #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) ();

  logic                  empty;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  empty,
    input  data_out,
    input  m_ready,
    output rd_en,
    output m_data,
    output m_valid
  );

  modport slave (
    output empty,
    output data_out,
    output m_ready,
    input  rd_en,
    input  m_data,
    input  m_valid
  );

endinterface

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain -- drains a first-word-fall-through FIFO into a valid/ready
// stream through a 2-entry skid buffer, sustaining one word per cycle.
//   clk_rd    : read-domain clock, all state on its rising edge.
//   rst_n     : asynchronous active-low reset.
//   enable    : permits fetching; buffered words still drain when low.
//   flush     : synchronous clear of the buffered words.
//   bus       : FIFO read port and downstream stream (master modport).
//   words_rd  : wrapping count of completed downstream transfers.
//   proto_err : sticky flag, pop was issued while the FIFO was empty.
module fifo_rd_drain
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_rd,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 flush,
  fifo_rd_drain_if.master      bus,
  output logic [CNT_WIDTH-1:0] words_rd,
  output logic                 proto_err
);

  occ_state_e            state_r;
  occ_state_e            state_nxt_s;
  logic [DATA_WIDTH-1:0] slot0_r;      // oldest entry, drives m_data
  logic [DATA_WIDTH-1:0] slot1_r;
  logic [DATA_WIDTH-1:0] slot0_nxt_s;
  logic [DATA_WIDTH-1:0] slot1_nxt_s;
  logic                  m_valid_r;
  logic [CNT_WIDTH-1:0]  words_rd_r;
  logic                  proto_err_r;
  logic                  xfer_s;
  logic                  pop_s;

  assign xfer_s = m_valid_r & bus.m_ready;

  // Pop decision: a full buffer only accepts a word when the head leaves
  // in the same cycle; pops are held off during reset and flush.
  always_comb begin
    pop_s = 1'b0;
    if (rst_n && enable && !bus.empty && !flush &&
        ((state_r != OCC_TWO) || xfer_s)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Occupancy next state and skid-buffer contents.
  always_comb begin
    state_nxt_s = state_r;
    slot0_nxt_s = slot0_r;
    slot1_nxt_s = slot1_r;
    if (flush) begin
      state_nxt_s = OCC_EMPTY;
      slot0_nxt_s = {DATA_WIDTH{1'b0}};
      slot1_nxt_s = {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        OCC_EMPTY: begin
          if (pop_s) begin
            slot0_nxt_s = bus.data_out;
            state_nxt_s = OCC_ONE;
          end else begin
            state_nxt_s = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (pop_s && xfer_s) begin
            slot0_nxt_s = bus.data_out;
            state_nxt_s = OCC_ONE;
          end else if (pop_s) begin
            slot1_nxt_s = bus.data_out;
            state_nxt_s = OCC_TWO;
          end else if (xfer_s) begin
            state_nxt_s = OCC_EMPTY;
          end else begin
            state_nxt_s = OCC_ONE;
          end
        end
        OCC_TWO: begin
          if (xfer_s) begin
            slot0_nxt_s = slot1_r;
            if (pop_s) begin
              slot1_nxt_s = bus.data_out;
              state_nxt_s = OCC_TWO;
            end else begin
              state_nxt_s = OCC_ONE;
            end
          end else begin
            state_nxt_s = OCC_TWO;
          end
        end
        default: begin
          state_nxt_s = OCC_EMPTY;
        end
      endcase
    end
  end

  // State, buffer, valid, transfer counter and protocol error registers.
  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= OCC_EMPTY;
      slot0_r     <= {DATA_WIDTH{1'b0}};
      slot1_r     <= {DATA_WIDTH{1'b0}};
      m_valid_r   <= 1'b0;
      words_rd_r  <= {CNT_WIDTH{1'b0}};
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      slot0_r     <= slot0_nxt_s;
      slot1_r     <= slot1_nxt_s;
      m_valid_r   <= (state_nxt_s != OCC_EMPTY);
      // A transfer in a flush cycle still completes and is counted.
      if (xfer_s) begin
        words_rd_r <= words_rd_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        words_rd_r <= words_rd_r;
      end
      proto_err_r <= proto_err_r | (pop_s & bus.empty);
    end
  end

  assign bus.rd_en   = pop_s;
  assign bus.m_data  = slot0_r;
  assign bus.m_valid = m_valid_r;
  assign words_rd    = words_rd_r;
  assign proto_err   = proto_err_r;

endmodule
